// File: rtl/sid_wr_sched_pkg.sv
// rtl/sid_wr_sched_pkg.sv - shared types and constants for the SID write scheduler
package sid_wr_sched_pkg;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_wr_t;

  localparam logic [4:0] SID_REG_LAST_WR = 5'h18;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} sid_wr_state_e;

  // Registers above 0x18 are read-only or unused on the 6581.
  function automatic logic sid_writable(input logic [4:0] addr);
    return addr <= SID_REG_LAST_WR;
  endfunction

endpackage

// File: rtl/sid_wr_sched_if.sv
// rtl/sid_wr_sched_if.sv - two-requester write request bundle
interface sid_wr_sched_if;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][4:0] req_addr;
  logic [1:0][7:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/sid_wr_sched_fifo.sv
// rtl/sid_wr_sched_fifo.sv - synchronous write buffer with flush and level counter
module sid_wr_fifo
  import sid_wr_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  sid_wr_t                  i_wr,
  output sid_wr_t                  o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  sid_wr_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr;
    end
  end

  // Pointers wrap naturally; full/empty come only from the level counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_FULL);

endmodule

// File: rtl/sid_wr_sched.sv
// rtl/sid_wr_sched.sv - arbitrates two write sources and replays them to the SID paced by clk_en
module sid_wr_sched
  import sid_wr_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_TICKS  = 1
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          i_clk_en,
  input  logic                          i_flush,
  sid_wr_sched_if.slave                 i_req,
  output logic [4:0]                    o_sid_addr,
  output logic [7:0]                    o_sid_data,
  output logic                          o_sid_n_cs,
  output logic                          o_drop_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_busy
);

  localparam logic [3:0] GAP_LAST = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

  sid_wr_state_e r_state;
  logic          r_rr;
  logic [3:0]    r_gap_cnt;
  logic [4:0]    r_sid_addr;
  logic [7:0]    r_sid_data;
  logic          r_sid_n_cs;
  logic          r_drop_pulse;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_can_grant;
  logic          w_transfer;
  logic          w_grant_idx;
  sid_wr_t       w_wr;
  sid_wr_t       w_head;

  // A pop in the same clk frees a slot, so a full FIFO can still accept.
  assign w_pop       = (r_state == IDLE) && !w_empty && !i_flush;
  assign w_can_grant = (!w_full || w_pop) && !i_flush;
  assign w_transfer  = w_can_grant && (|i_req.req_valid);
  assign w_push      = w_transfer && sid_writable(w_wr.addr);

  always_comb begin
    w_grant_idx = 1'b0;
    case (i_req.req_valid)
      2'b01:   w_grant_idx = 1'b0;
      2'b10:   w_grant_idx = 1'b1;
      2'b11:   w_grant_idx = ~r_rr;
      default: w_grant_idx = 1'b0;
    endcase
  end

  always_comb begin
    i_req.req_ready = 2'b00;
    if (w_transfer) begin
      i_req.req_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_wr.addr = i_req.req_addr[w_grant_idx];
  assign w_wr.data = i_req.req_data[w_grant_idx];

  sid_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_wr    (w_wr),
    .o_head  (w_head),
    .o_level (o_fifo_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_rr         <= 1'b0;
      r_gap_cnt    <= '0;
      r_sid_addr   <= '0;
      r_sid_data   <= '0;
      r_sid_n_cs   <= 1'b1;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= w_transfer && !sid_writable(w_wr.addr);
      if (w_transfer) r_rr <= w_grant_idx;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_sid_addr <= w_head.addr;
            r_sid_data <= w_head.data;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (i_flush) begin
            r_state <= IDLE;
          end else if (i_clk_en) begin
            r_sid_n_cs <= 1'b0;
            r_state    <= STROBE;
          end
        end
        // A strobe in flight always runs its full tick, flush or not.
        STROBE: begin
          if (i_clk_en) begin
            r_sid_n_cs <= 1'b1;
            r_gap_cnt  <= '0;
            r_state    <= (GAP_TICKS == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (i_clk_en) begin
            if (r_gap_cnt == GAP_LAST) r_state <= IDLE;
            else                        r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sid_addr   = r_sid_addr;
  assign o_sid_data   = r_sid_data;
  assign o_sid_n_cs   = r_sid_n_cs;
  assign o_drop_pulse = r_drop_pulse;
  assign o_busy       = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_sid_wr_sched.sv
// tb/tb_sid_wr_sched.sv - self-checking bench for sid_wr_sched
module tb_sid_wr_sched;
  import sid_wr_sched_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       sid_n_cs;
  logic       drop_pulse;
  logic [4:0] fifo_level;
  logic       busy;

  sid_wr_sched_if req_if();

  sid_wr_sched #(.FIFO_DEPTH(16), .GAP_TICKS(1)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_clk_en     (clk_en),
    .i_flush      (flush),
    .i_req        (req_if),
    .o_sid_addr   (sid_addr),
    .o_sid_data   (sid_data),
    .o_sid_n_cs   (sid_n_cs),
    .o_drop_pulse (drop_pulse),
    .o_fifo_level (fifo_level),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // clk_en every 52 clk while tick_en is set
  logic tick_en = 1'b1;
  int   tick_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!tick_en) begin
      tick_cnt = 0;
      clk_en   = 1'b0;
    end else begin
      clk_en   = (tick_cnt == 51);
      tick_cnt = (tick_cnt == 51) ? 0 : tick_cnt + 1;
    end
  end

  // Scoreboard: accepted writable requests queue up, each n_cs fall pops one.
  sid_wr_t exp_q[$];
  int      grant_log[$];
  int      strobe_cnt = 0;
  int      cyc = 0;
  int      last_fall = 0;
  int      last_gap = 0;
  int      width = 0;
  bit      in_strobe = 1'b0;
  bit      prev_ncs = 1'b1;
  logic    en_at_neg;

  always begin
    @(negedge clk);
    en_at_neg = clk_en;
    if (!n_reset) begin
      exp_q.delete();
    end else begin
      if (flush) exp_q.delete();
      for (int i = 0; i < 2; i++) begin
        if (req_if.req_valid[i] && req_if.req_ready[i]) begin
          grant_log.push_back(i);
          if (req_if.req_addr[i] <= SID_REG_LAST_WR)
            exp_q.push_back('{addr: req_if.req_addr[i], data: req_if.req_data[i]});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!n_reset) begin
      exp_q.delete();
      in_strobe = 1'b0;
      prev_ncs  = 1'b1;
    end else begin
      if (prev_ncs && !sid_n_cs) begin
        sid_wr_t e;
        strobe_cnt++;
        chk("ncs_fall_on_tick", en_at_neg, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_strobe: got addr %0h data %0h expected no strobe", sid_addr, sid_data);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_addr", sid_addr, e.addr);
          chk("strobe_data", sid_data, e.data);
        end
        last_gap  = cyc - last_fall;
        last_fall = cyc;
        in_strobe = 1'b1;
        width     = 1;
      end else if (in_strobe && !sid_n_cs) begin
        width++;
      end else if (in_strobe && sid_n_cs) begin
        chk("ncs_width", width, 52);
        in_strobe = 1'b0;
      end
      prev_ncs = sid_n_cs;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int r, input logic [4:0] a, input logic [7:0] d, input string name);
    req_if.req_valid    = 2'b00;
    req_if.req_valid[r] = 1'b1;
    req_if.req_addr[r]  = a;
    req_if.req_data[r]  = d;
    @(negedge clk);
    chk(name, req_if.req_ready, 32'(1) << r);
    step();
    req_if.req_valid = 2'b00;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while ((busy !== 1'b0 || sid_n_cs !== 1'b1) && n < bound) begin
      step();
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_ncs_low(input string name, input int bound);
    int n = 0;
    while (sid_n_cs !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    chk(name, sid_n_cs, 0);
  endtask

  typedef struct {
    int         req;
    logic [4:0] addr;
    logic [7:0] data;
    bit         drop;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int         s;
    int         got;
    int         guard;
    logic [1:0] g;
    logic [4:0] lvl;

    vecs[0] = '{0, 5'h18, 8'h0F, 1'b0};
    vecs[1] = '{0, 5'h1B, 8'hAA, 1'b1};
    vecs[2] = '{1, 5'h00, 8'h55, 1'b0};
    vecs[3] = '{1, 5'h19, 8'h01, 1'b1};
    vecs[4] = '{0, 5'h1F, 8'hFF, 1'b1};
    vecs[5] = '{1, 5'h0C, 8'hC3, 1'b0};

    req_if.req_valid = 2'b00;
    req_if.req_addr  = '0;
    req_if.req_data  = '0;

    repeat (3) step();
    chk("rst_ncs", sid_n_cs, 1);
    chk("rst_addr", sid_addr, 0);
    chk("rst_data", sid_data, 0);
    chk("rst_ready", req_if.req_ready, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    n_reset = 1'b1;
    step();

    // Both requesters valid continuously from rr=0
    req_if.req_valid   = 2'b11;
    req_if.req_addr[0] = 5'h01;
    req_if.req_addr[1] = 5'h02;
    req_if.req_data[0] = 8'h10;
    req_if.req_data[1] = 8'h20;
    got = 0;
    guard = 0;
    while (got < 6 && guard < 40) begin
      @(negedge clk);
      g = req_if.req_ready;
      step();
      guard++;
      if (g[0]) begin req_if.req_data[0] = req_if.req_data[0] + 8'd1; got++; end
      if (g[1]) begin req_if.req_data[1] = req_if.req_data[1] + 8'd1; got++; end
    end
    req_if.req_valid = 2'b00;
    chk("rr_transfers", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("rr_grant_%0d", i), grant_log[i], (i % 2 == 0) ? 1 : 0);
    wait_idle("rr_drain", 2000);
    chk("rr_strobes", strobe_cnt, 6);
    chk("rr_queue_empty", exp_q.size(), 0);
    chk("throughput_gap", last_gap, 156);

    // Single writes including read-only address drops
    for (int i = 0; i < 6; i++) begin
      s = strobe_cnt;
      push_one(vecs[i].req, vecs[i].addr, vecs[i].data, $sformatf("vec%0d_ready", i));
      chk($sformatf("vec%0d_drop", i), drop_pulse, 32'(vecs[i].drop));
      if (vecs[i].drop) chk($sformatf("vec%0d_level", i), fifo_level, 0);
      step();
      chk($sformatf("vec%0d_drop_end", i), drop_pulse, 0);
      wait_idle($sformatf("vec%0d_idle", i), 400);
      chk($sformatf("vec%0d_strobes", i), strobe_cnt - s, vecs[i].drop ? 0 : 1);
    end

    // Fill to full with the FSM parked in SETUP
    s = strobe_cnt;
    tick_en = 1'b0;
    step();
    step();
    push_one(0, 5'h05, 8'h00, "fill_first_ready");
    step();
    chk("fill_first_level", fifo_level, 0);
    chk("fill_first_busy", busy, 1);
    for (int i = 1; i <= 16; i++)
      push_one(0, 5'(i), 8'(i + 8'h40), $sformatf("fill_ready_%0d", i));
    chk("fill_level_full", fifo_level, 16);
    req_if.req_valid[0] = 1'b1;
    req_if.req_addr[0]  = 5'h11;
    req_if.req_data[0]  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_ready", req_if.req_ready, 0);
      step();
    end
    chk("full_level_hold", fifo_level, 16);
    tick_en = 1'b1;
    guard = 0;
    g = 2'b00;
    lvl = '0;
    while (g == 2'b00 && guard < 400) begin
      @(negedge clk);
      g   = req_if.req_ready;
      lvl = fifo_level;
      step();
      guard++;
    end
    req_if.req_valid = 2'b00;
    chk("full_accept_ready", g, 2'b01);
    chk("full_accept_level_before", lvl, 16);
    chk("full_accept_level_after", fifo_level, 16);
    wait_idle("fill_drain", 4000);
    chk("fill_strobes", strobe_cnt - s, 18);

    // Flush in SETUP with three queued, with a same-clk push attempt
    tick_en = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++)
      push_one(0, 5'(i + 2), 8'(i + 8'h80), "flsetup_push_ready");
    chk("flsetup_level", fifo_level, 3);
    flush = 1'b1;
    req_if.req_valid[1] = 1'b1;
    req_if.req_addr[1]  = 5'h03;
    req_if.req_data[1]  = 8'h33;
    @(negedge clk);
    chk("flush_ready", req_if.req_ready, 0);
    step();
    flush = 1'b0;
    req_if.req_valid = 2'b00;
    chk("flsetup_level_after", fifo_level, 0);
    chk("flsetup_busy_after", busy, 0);
    chk("flsetup_ncs_after", sid_n_cs, 1);
    s = strobe_cnt;
    tick_en = 1'b1;
    repeat (300) step();
    chk("flsetup_no_strobe", strobe_cnt, s);

    // Flush during STROBE: pulse completes, rest is discarded
    s = strobe_cnt;
    for (int i = 0; i < 3; i++)
      push_one(1, 5'(i + 8), 8'(i + 8'hA0), "flstrobe_push_ready");
    wait_ncs_low("flstrobe_ncs_low", 200);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flstrobe_level_after", fifo_level, 0);
    wait_idle("flstrobe_idle", 400);
    chk("flstrobe_strobes", strobe_cnt - s, 1);

    // Async reset mid-STROBE
    push_one(0, 5'h04, 8'h44, "rst_push_ready_a");
    push_one(0, 5'h06, 8'h66, "rst_push_ready_b");
    wait_ncs_low("rst_ncs_low", 200);
    step();
    #2;
    n_reset = 1'b0;
    #1;
    chk("rst_mid_ncs", sid_n_cs, 1);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (3) step();
    #1;
    n_reset = 1'b1;
    s = strobe_cnt;
    repeat (300) step();
    chk("rst_no_strobe", strobe_cnt, s);
    chk("rst_final_ncs", sid_n_cs, 1);
    chk("rst_final_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
